fft_stage_dispatch: RTL and testbench

Parametrised FFT stage front-end. It buffers one N-point complex frame arriving as two samples per beat, then replays it as butterfly operand pairs (i, i+h) with the matching twiddle factor W_N^k for stage STAGE. It sits between consecutive radix-2 butterfly units in the vowel-classifier FFT chain. It generalises the fixed 8-point stage-2 dispatcher to any power-of-two N and any stage, and adds ready/valid backpressure on both sides plus a last-pair marker.

---
 rtl/fft_pkg.sv | 29 ++
 rtl/fft_twiddle_rom.sv | 34 +++
 rtl/fft_stage_dispatch.sv | 151 +++++++++++++++
 tb/tb_fft_stage_dispatch.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT chain definitions: dispatcher states, log2 and word-width helpers.
package fft_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Ceiling log2, evaluated at elaboration for parameter-derived widths.
    function automatic int unsigned log2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Sample word width from its MSB index.
    function automatic int unsigned sample_w(input int unsigned msb);
        return msb + 1;
    endfunction

    // Coefficient word width from its MSB index (Q_OUT fraction bits plus sign).
    function automatic int unsigned coeff_w(input int unsigned msb);
        return msb + 1;
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Twiddle table W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) for k < N/2, built at elaboration.
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned Q_OUT = 15
) (
    input  logic [log2(N)-2:0] k,
    output logic [Q_OUT:0]     coeff_real_c,
    output logic [Q_OUT:0]     coeff_imag_c
);

    localparam int unsigned CW      = coeff_w(Q_OUT);
    localparam int unsigned DEPTH   = N / 2;
    localparam real         TWO_PI  = 6.283185307179586;
    localparam real         SCALE   = real'(64'd1 << Q_OUT);
    localparam int          MAX_POS = int'((64'd1 << Q_OUT) - 64'd1);

    logic [CW-1:0] rom_re [DEPTH];
    logic [CW-1:0] rom_im [DEPTH];

    // One constant entry per k; +1.0 saturates to the largest positive code.
    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam real ANG = TWO_PI * real'(g) / real'(N);
        localparam int  RE  = $rtoi($floor($cos(ANG) * SCALE + 0.5));
        localparam int  IM  = $rtoi($floor(-$sin(ANG) * SCALE + 0.5));
        assign rom_re[g] = CW'((RE > MAX_POS) ? MAX_POS : RE);
        assign rom_im[g] = CW'((IM > MAX_POS) ? MAX_POS : IM);
    end

    assign coeff_real_c = rom_re[k];
    assign coeff_imag_c = rom_im[k];

endmodule

// File: rtl/fft_stage_dispatch.sv
// FFT stage front-end: buffers one N-point frame (two samples per beat) and replays
// it as butterfly operand pairs (i, i+h) with twiddle W_N^k for the configured stage.
module fft_stage_dispatch
    import fft_pkg::*;
#(
    parameter int unsigned Q_IN  = 15,
    parameter int unsigned Q_OUT = 15,
    parameter int unsigned N     = 8,
    parameter int unsigned STAGE = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         valid_in,
    output logic         ready_in,
    input  logic [Q_IN:0]  data_in_real_0,
    input  logic [Q_IN:0]  data_in_imag_0,
    input  logic [Q_IN:0]  data_in_real_1,
    input  logic [Q_IN:0]  data_in_imag_1,
    output logic         valid_out,
    input  logic         ready_out,
    output logic         last_out,
    output logic [Q_OUT:0] data_out_real_0,
    output logic [Q_OUT:0] data_out_imag_0,
    output logic [Q_OUT:0] data_out_real_1,
    output logic [Q_OUT:0] data_out_imag_1,
    output logic [Q_OUT:0] coeff_out_real,
    output logic [Q_OUT:0] coeff_out_imag
);

    localparam int unsigned LOGN = log2(N);
    localparam int unsigned PW   = LOGN - 1;
    localparam int unsigned HALF = N / 2;
    localparam int unsigned H    = N >> (STAGE + 1);
    localparam int unsigned HSH  = log2(H);
    localparam int unsigned IW   = sample_w(Q_IN);
    localparam int unsigned OW   = coeff_w(Q_OUT);

    state_t               state;
    logic [PW-1:0]        beat_cnt;
    logic [PW-1:0]        pair_cnt;
    logic                 drain_armed;
    logic                 pairs_done;

    logic signed [IW-1:0] mem_re [N];
    logic signed [IW-1:0] mem_im [N];

    logic [PW-1:0]        j_c;
    logic [PW-1:0]        k_c;
    logic [LOGN-1:0]      idx_a_c;
    logic [LOGN-1:0]      idx_b_c;
    logic [OW-1:0]        tw_re_c;
    logic [OW-1:0]        tw_im_c;
    logic                 beat_fire_c;
    logic                 load_c;
    logic                 last_accept_c;

    // Pair p -> (i, i+h, k): j = p mod h picks the offset, p / h picks the 2h-wide group.
    always_comb begin
        j_c     = pair_cnt & PW'(H - 1);
        idx_a_c = ((LOGN'(pair_cnt) >> HSH) << (HSH + 1)) | LOGN'(j_c);
        idx_b_c = idx_a_c | LOGN'(H);
        k_c     = j_c << STAGE;
    end

    assign beat_fire_c   = (state == FILL) && valid_in && ready_in;
    assign load_c        = (state == DRAIN) && drain_armed && !pairs_done && (!valid_out || ready_out);
    assign last_accept_c = valid_out && ready_out && last_out;

    fft_twiddle_rom #(
        .N     (N),
        .Q_OUT (Q_OUT)
    ) u_twiddle (
        .k            (k_c),
        .coeff_real_c (tw_re_c),
        .coeff_imag_c (tw_im_c)
    );

    // Frame buffer in natural order; contents survive reset and are simply overwritten.
    always_ff @(posedge clk) begin
        if (beat_fire_c) begin
            mem_re[{beat_cnt, 1'b0}] <= data_in_real_0;
            mem_im[{beat_cnt, 1'b0}] <= data_in_imag_0;
            mem_re[{beat_cnt, 1'b1}] <= data_in_real_1;
            mem_im[{beat_cnt, 1'b1}] <= data_in_imag_1;
        end
    end

    // Fill/drain sequencing and the registered output pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= FILL;
            beat_cnt        <= '0;
            pair_cnt        <= '0;
            drain_armed     <= 1'b0;
            pairs_done      <= 1'b0;
            ready_in        <= 1'b1;
            valid_out       <= 1'b0;
            last_out        <= 1'b0;
            data_out_real_0 <= '0;
            data_out_imag_0 <= '0;
            data_out_real_1 <= '0;
            data_out_imag_1 <= '0;
            coeff_out_real  <= '0;
            coeff_out_imag  <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (beat_fire_c) begin
                        if (beat_cnt == PW'(HALF - 1)) begin
                            beat_cnt <= '0;
                            state    <= DRAIN;
                            ready_in <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + PW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // One turnaround cycle after entering DRAIN before the first pair loads.
                    drain_armed <= 1'b1;
                    if (last_accept_c) begin
                        valid_out   <= 1'b0;
                        last_out    <= 1'b0;
                        pair_cnt    <= '0;
                        beat_cnt    <= '0;
                        drain_armed <= 1'b0;
                        pairs_done  <= 1'b0;
                        ready_in    <= 1'b1;
                        state       <= FILL;
                    end else if (load_c) begin
                        valid_out       <= 1'b1;
                        last_out        <= (pair_cnt == PW'(HALF - 1));
                        data_out_real_0 <= OW'(mem_re[idx_a_c]);
                        data_out_imag_0 <= OW'(mem_im[idx_a_c]);
                        data_out_real_1 <= OW'(mem_re[idx_b_c]);
                        data_out_imag_1 <= OW'(mem_im[idx_b_c]);
                        coeff_out_real  <= tw_re_c;
                        coeff_out_imag  <= tw_im_c;
                        if (pair_cnt == PW'(HALF - 1)) begin
                            pairs_done <= 1'b1;
                        end else begin
                            pair_cnt <= pair_cnt + PW'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stage_dispatch.sv
// Scoreboard bench: three N=8 instances (stages 0,1,2) share one input bus, plus an
// N=16 / Q_IN=11 instance on its own bus. Expected pairs are queued per instance.
module tb_fft_stage_dispatch;

    typedef struct {
        int r0; int i0; int r1; int i1; int wr; int wi; int last;
    } pair_t;

    logic        clk;
    logic        reset_n;
    logic        vin8;
    logic [15:0] d8r0, d8i0, d8r1, d8i1;
    logic        vin16;
    logic [11:0] d16r0, d16i0, d16r1, d16i1;
    logic        rtog;

    logic        rin  [4];
    logic        vout [4];
    logic        lout [4];
    logic        rout [4];
    logic [15:0] or0 [4], oi0 [4], or1 [4], oi1 [4], ocr [4], oci [4];

    int checks   = 0;
    int failures = 0;
    int hs [4]   = '{0, 0, 0, 0};
    int tcnt     = 0;
    pair_t sb [4][$];

    // Hand-derived pair tables for N=8: stage 0 (h=4), stage 1 (h=2), stage 2 (h=1).
    int a_tab [3][4] = '{'{0, 1, 2, 3}, '{0, 1, 4, 5}, '{0, 2, 4, 6}};
    int b_tab [3][4] = '{'{4, 5, 6, 7}, '{2, 3, 6, 7}, '{1, 3, 5, 7}};
    int k_tab [3][4] = '{'{0, 1, 2, 3}, '{0, 2, 0, 2}, '{0, 0, 0, 0}};
    int wr8 [4]  = '{32767, 23170, 0, -23170};
    int wi8 [4]  = '{0, -23170, -32768, -23170};
    int wr16 [8] = '{32767, 30274, 23170, 12540, 0, -12540, -23170, -30274};
    int wi16 [8] = '{0, -12540, -23170, -30274, -32768, -30274, -23170, -12540};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rout[0] = 1'b1;
    assign rout[1] = rtog;
    assign rout[2] = 1'b1;
    assign rout[3] = 1'b1;

    for (genvar s = 0; s < 3; s++) begin : g_n8
        fft_stage_dispatch #(.Q_IN(15), .Q_OUT(15), .N(8), .STAGE(s)) dut (
            .clk(clk), .reset_n(reset_n), .valid_in(vin8), .ready_in(rin[s]),
            .data_in_real_0(d8r0), .data_in_imag_0(d8i0),
            .data_in_real_1(d8r1), .data_in_imag_1(d8i1),
            .valid_out(vout[s]), .ready_out(rout[s]), .last_out(lout[s]),
            .data_out_real_0(or0[s]), .data_out_imag_0(oi0[s]),
            .data_out_real_1(or1[s]), .data_out_imag_1(oi1[s]),
            .coeff_out_real(ocr[s]), .coeff_out_imag(oci[s]));
    end

    fft_stage_dispatch #(.Q_IN(11), .Q_OUT(15), .N(16), .STAGE(0)) dut16 (
        .clk(clk), .reset_n(reset_n), .valid_in(vin16), .ready_in(rin[3]),
        .data_in_real_0(d16r0), .data_in_imag_0(d16i0),
        .data_in_real_1(d16r1), .data_in_imag_1(d16i1),
        .valid_out(vout[3]), .ready_out(rout[3]), .last_out(lout[3]),
        .data_out_real_0(or0[3]), .data_out_imag_0(oi0[3]),
        .data_out_real_1(or1[3]), .data_out_imag_1(oi1[3]),
        .coeff_out_real(ocr[3]), .coeff_out_imag(oci[3]));

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Downstream ready pattern 1,0,0,1 repeating for the stage-1 instance.
    initial begin
        rtog = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tcnt++;
            rtog = ((tcnt % 4) == 0) || ((tcnt % 4) == 3);
        end
    end

    // Monitor: every cycle a pair is presented it must equal the queue head;
    // the head is popped only when the handshake completes.
    always @(negedge clk) begin
        pair_t act;
        pair_t e;
        if (reset_n) begin
            for (int id = 0; id < 4; id++) begin
                if (vout[id]) begin
                    act.r0   = int'($signed(or0[id]));
                    act.i0   = int'($signed(oi0[id]));
                    act.r1   = int'($signed(or1[id]));
                    act.i1   = int'($signed(oi1[id]));
                    act.wr   = int'($signed(ocr[id]));
                    act.wi   = int'($signed(oci[id]));
                    act.last = int'(lout[id]);
                    checks++;
                    if (sb[id].size() == 0) begin
                        failures++;
                        $display("FAIL pair inst%0d: got unexpected pair (%0d,%0d)(%0d,%0d) w(%0d,%0d) last=%0d",
                                 id, act.r0, act.i0, act.r1, act.i1, act.wr, act.wi, act.last);
                    end else begin
                        e = sb[id][0];
                        if (act.r0 != e.r0 || act.i0 != e.i0 || act.r1 != e.r1 || act.i1 != e.i1 ||
                            act.wr != e.wr || act.wi != e.wi || act.last != e.last) begin
                            failures++;
                            $display("FAIL pair inst%0d: got (%0d,%0d)(%0d,%0d) w(%0d,%0d) last=%0d expected (%0d,%0d)(%0d,%0d) w(%0d,%0d) last=%0d",
                                     id, act.r0, act.i0, act.r1, act.i1, act.wr, act.wi, act.last,
                                     e.r0, e.i0, e.r1, e.i1, e.wr, e.wi, e.last);
                        end
                        if (rout[id]) begin
                            void'(sb[id].pop_front());
                            hs[id]++;
                        end
                    end
                end
            end
        end
    end

    // Send one N=8 frame (real=base+n, imag=-(base+n)) with an optional 3-cycle gap,
    // then check first-pair latency and that DRAIN ignores valid_in.
    task automatic send8(input int base, input int gap_at, input bit junk);
        pair_t e;
        int    smp [8];
        for (int n = 0; n < 8; n++) smp[n] = base + n;
        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < 4; p++) begin
                e.r0   = smp[a_tab[s][p]];
                e.i0   = -smp[a_tab[s][p]];
                e.r1   = smp[b_tab[s][p]];
                e.i1   = -smp[b_tab[s][p]];
                e.wr   = wr8[k_tab[s][p]];
                e.wi   = wi8[k_tab[s][p]];
                e.last = (p == 3) ? 1 : 0;
                sb[s].push_back(e);
            end
        end
        for (int b = 0; b < 4; b++) begin
            if (b == gap_at) begin
                vin8 = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            vin8 = 1'b1;
            d8r0 = 16'(smp[2*b]);
            d8i0 = 16'(-smp[2*b]);
            d8r1 = 16'(smp[2*b+1]);
            d8i1 = 16'(-smp[2*b+1]);
            @(posedge clk);
            #1;
        end
        if (junk) begin
            vin8 = 1'b1;
            d8r0 = 16'h7777; d8i0 = 16'h7777; d8r1 = 16'h7777; d8i1 = 16'h7777;
        end else begin
            vin8 = 1'b0;
        end
        @(negedge clk);
        chk("latency_t+0_valid", int'(vout[2]), 0);
        chk("drain_ready_in_0", int'(rin[0]), 0);
        @(negedge clk);
        chk("latency_t+1_valid", int'(vout[2]), 0);
        chk("drain_ready_in_1", int'(rin[0]), 0);
        @(negedge clk);
        chk("latency_t+2_valid", int'(vout[2]), 1);
        chk("drain_ready_in_2", int'(rin[0]), 0);
        vin8 = 1'b0;
    endtask

    task automatic wait_idle8(input string name);
        int n;
        n = 0;
        while (!(rin[0] && rin[1] && rin[2]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(rin[0] && rin[1] && rin[2]), 1);
        for (int s = 0; s < 3; s++) chk("sb_drained", sb[s].size(), 0);
    endtask

    // Send one N=16 frame: real=-2048 everywhere, imag=-(base+n); one beat per cycle.
    task automatic send16(input int base);
        pair_t e;
        int    n;
        for (int p = 0; p < 8; p++) begin
            e.r0   = -2048;
            e.i0   = -(base + p);
            e.r1   = -2048;
            e.i1   = -(base + p + 8);
            e.wr   = wr16[p];
            e.wi   = wi16[p];
            e.last = (p == 7) ? 1 : 0;
            sb[3].push_back(e);
        end
        for (int b = 0; b < 8; b++) begin
            vin16 = 1'b1;
            d16r0 = 12'h800;
            d16i0 = 12'(-(base + 2*b));
            d16r1 = 12'h800;
            d16i1 = 12'(-(base + 2*b + 1));
            chk("n16_beat_ready_in", int'(rin[3]), 1);
            @(posedge clk);
            #1;
        end
        vin16 = 1'b0;
        n = 0;
        while (!rin[3] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("n16_frame_done", int'(rin[3]), 1);
        chk("n16_sb_drained", sb[3].size(), 0);
    endtask

    initial begin
        int h0, h1, n;
        reset_n = 1'b0;
        vin8 = 1'b0; d8r0 = '0; d8i0 = '0; d8r1 = '0; d8i1 = '0;
        vin16 = 1'b0; d16r0 = '0; d16i0 = '0; d16r1 = '0; d16i1 = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int id = 0; id < 4; id++) begin
            chk("reset_valid_out", int'(vout[id]), 0);
            chk("reset_last_out", int'(lout[id]), 0);
            chk("reset_data", int'(or0[id] | oi0[id] | or1[id] | oi1[id]), 0);
            chk("reset_coeff", int'(ocr[id] | oci[id]), 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int id = 0; id < 4; id++) chk("ready_in_after_reset", int'(rin[id]), 1);

        // Frame 1: samples 0..7, gap mid-fill, valid_in held high into DRAIN.
        h0 = hs[0]; h1 = hs[1];
        send8(0, 2, 1'b1);
        wait_idle8("frame1_done");
        chk("frame1_handshakes_s0", hs[0] - h0, 4);
        chk("frame1_handshakes_s1", hs[1] - h1, 4);

        // Frame 2: reset asynchronously after two pairs have been accepted.
        h0 = hs[0];
        send8(0, -1, 1'b0);
        n = 0;
        while ((hs[0] - h0) < 2 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("two_pairs_before_reset", hs[0] - h0, 2);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_valid", int'(vout[0]), 0);
        chk("async_reset_last", int'(lout[0]), 0);
        chk("async_reset_data", int'(or0[0] | oi0[0] | or1[0] | oi1[0]), 0);
        chk("async_reset_coeff", int'(ocr[0] | oci[0]), 0);
        chk("async_reset_valid_s1", int'(vout[1]), 0);
        chk("async_reset_valid_s2", int'(vout[2]), 0);
        for (int s = 0; s < 3; s++) sb[s].delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) chk("ready_in_after_async_reset", int'(rin[s]), 1);

        // Frame 3: samples 10..17 must drain from (10,14) with nothing left over.
        h0 = hs[0]; h1 = hs[1];
        send8(10, -1, 1'b0);
        wait_idle8("frame3_done");
        chk("frame3_handshakes_s0", hs[0] - h0, 4);
        chk("frame3_handshakes_s1", hs[1] - h1, 4);

        // N=16, Q_IN=11: sign extension and back-to-back frames.
        send16(0);
        send16(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
